// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch aligner.
// Covers the FSM encoding, the RVC length rule and the cache byte-order swap.
package fetch_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    localparam logic [1:0] OPC_LEN32 = 2'b11;

    function automatic logic is_rvc(input logic [15:0] h);
        return h[1:0] != OPC_LEN32;
    endfunction

    // The I-cache delivers words with the first byte in the top lane.
    function automatic logic [31:0] swap_bytes(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/fetch_aligner.sv
// Fetch front end: reads 32-bit words from the I-cache and realigns the mixed
// 16/32-bit halfword stream into one instruction per valid/ready handshake.
module fetch_aligner
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        icache_ren,
    output logic [29:0] icache_addr,
    input  logic        icache_stall,
    input  logic [31:0] icache_rdata,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        compressed_o
);

    state_t      state, state_nxt;
    logic [29:0] fetch_addr, fetch_addr_nxt;
    logic        skip_low, skip_low_nxt;
    logic [15:0] hbuf, hbuf_nxt;
    logic        hbuf_v, hbuf_v_nxt;
    logic [31:0] hbuf_pc, hbuf_pc_nxt;
    logic [31:1] pend_pc, pend_pc_nxt;

    logic        valid_nxt;
    logic [31:0] instr_nxt;
    logic [31:0] pc_nxt;
    logic        compressed_nxt;

    logic [31:0] w;
    logic [31:0] word_pc;
    logic [31:1] target;
    logic        slot_free;
    logic        case_a;
    logic        ren;
    logic        unused_pc_bit;

    assign w             = swap_bytes(icache_rdata);
    assign word_pc       = {fetch_addr, 2'b00};
    assign slot_free     = !valid_o || ready_i;
    assign case_a        = hbuf_v && is_rvc(hbuf);
    assign ren           = (state == ST_DRAIN) || (slot_free && !case_a);
    assign icache_ren    = ren && !rst;
    assign icache_addr   = fetch_addr;
    assign unused_pc_bit = redirect_pc_i[0];

    always_comb begin
        // NOTE: every next-state signal defaults to its register value first, so
        // no branch can leave one unassigned and infer a latch.
        state_nxt      = state;
        fetch_addr_nxt = fetch_addr;
        skip_low_nxt   = skip_low;
        hbuf_nxt       = hbuf;
        hbuf_v_nxt     = hbuf_v;
        hbuf_pc_nxt    = hbuf_pc;
        pend_pc_nxt    = pend_pc;
        valid_nxt      = valid_o;
        instr_nxt      = instr_o;
        pc_nxt         = pc_o;
        compressed_nxt = compressed_o;
        target         = redirect_i ? redirect_pc_i[31:1] : pend_pc;

        if (state == ST_DRAIN) begin
            // Wait out the outstanding miss; the word it returns is dropped.
            if (redirect_i) begin
                pend_pc_nxt = redirect_pc_i[31:1];
            end
            if (!icache_stall) begin
                fetch_addr_nxt = target[31:2];
                skip_low_nxt   = target[1];
                state_nxt      = ST_RUN;
            end
        end else if (redirect_i) begin
            valid_nxt  = 1'b0;
            hbuf_v_nxt = 1'b0;
            if (icache_stall) begin
                state_nxt   = ST_DRAIN;
                pend_pc_nxt = redirect_pc_i[31:1];
            end else begin
                fetch_addr_nxt = redirect_pc_i[31:2];
                skip_low_nxt   = redirect_pc_i[1];
            end
        end else if (slot_free) begin
            if (case_a) begin
                valid_nxt      = 1'b1;
                instr_nxt      = {16'h0000, hbuf};
                pc_nxt         = hbuf_pc;
                compressed_nxt = 1'b1;
                hbuf_v_nxt     = 1'b0;
            end else if (icache_stall) begin
                valid_nxt = 1'b0;
            end else begin
                fetch_addr_nxt = fetch_addr + 30'd1;
                if (hbuf_v) begin
                    // Leftover low half completes with this word's low half.
                    valid_nxt      = 1'b1;
                    instr_nxt      = {w[15:0], hbuf};
                    pc_nxt         = hbuf_pc;
                    compressed_nxt = 1'b0;
                    hbuf_nxt       = w[31:16];
                    hbuf_pc_nxt    = word_pc + 32'd2;
                end else if (skip_low) begin
                    skip_low_nxt = 1'b0;
                    if (is_rvc(w[31:16])) begin
                        valid_nxt      = 1'b1;
                        instr_nxt      = {16'h0000, w[31:16]};
                        pc_nxt         = word_pc + 32'd2;
                        compressed_nxt = 1'b1;
                    end else begin
                        valid_nxt   = 1'b0;
                        hbuf_nxt    = w[31:16];
                        hbuf_pc_nxt = word_pc + 32'd2;
                        hbuf_v_nxt  = 1'b1;
                    end
                end else if (!is_rvc(w[15:0])) begin
                    valid_nxt      = 1'b1;
                    instr_nxt      = w;
                    pc_nxt         = word_pc;
                    compressed_nxt = 1'b0;
                end else begin
                    valid_nxt      = 1'b1;
                    instr_nxt      = {16'h0000, w[15:0]};
                    pc_nxt         = word_pc;
                    compressed_nxt = 1'b1;
                    hbuf_nxt       = w[31:16];
                    hbuf_pc_nxt    = word_pc + 32'd2;
                    hbuf_v_nxt     = 1'b1;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_RUN;
            fetch_addr   <= RESET_PC[31:2];
            skip_low     <= RESET_PC[1];
            hbuf         <= '0;
            hbuf_v       <= 1'b0;
            hbuf_pc      <= '0;
            pend_pc      <= '0;
            valid_o      <= 1'b0;
            instr_o      <= '0;
            pc_o         <= '0;
            compressed_o <= 1'b0;
        end else begin
            state        <= state_nxt;
            fetch_addr   <= fetch_addr_nxt;
            skip_low     <= skip_low_nxt;
            hbuf         <= hbuf_nxt;
            hbuf_v       <= hbuf_v_nxt;
            hbuf_pc      <= hbuf_pc_nxt;
            pend_pc      <= pend_pc_nxt;
            valid_o      <= valid_nxt;
            instr_o      <= instr_nxt;
            pc_o         <= pc_nxt;
            compressed_o <= compressed_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_aligner.sv
// Self-checking bench for fetch_aligner: directed scenarios plus a randomized
// run, all scored against an instruction-stream model built from program memory.
module tb_fetch_aligner;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        icache_ren;
    logic [29:0] icache_addr;
    logic        icache_stall;
    logic [31:0] icache_rdata;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        compressed_o;

    // Program memory in program byte order (low halfword = lower address).
    logic [31:0] mem [256];

    int          checks = 0;
    int          errors = 0;
    int          n_acc  = 0;
    logic [31:0] exp_pc;

    always #5 clk = ~clk;

    function automatic logic [31:0] bswap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    assign icache_rdata = bswap(mem[icache_addr[7:0]]);

    fetch_aligner #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .icache_ren   (icache_ren),
        .icache_addr  (icache_addr),
        .icache_stall (icache_stall),
        .icache_rdata (icache_rdata),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .compressed_o (compressed_o)
    );

    function automatic logic [15:0] hw_at(input logic [31:0] a);
        logic [31:0] wd;
        wd = mem[a[9:2]];
        return a[1] ? wd[31:16] : wd[15:0];
    endfunction

    // One clock: called at a negedge, scores the handshake 1 ns before the
    // posedge, returns at the next negedge.
    task automatic step();
        logic [15:0] h;
        logic [31:0] e_instr;
        logic        e_c;
        #4;
        if (!rst) begin
            if (redirect_i) begin
                exp_pc = {redirect_pc_i[31:1], 1'b0};
            end else if (valid_o && ready_i) begin
                h = hw_at(exp_pc);
                if (h[1:0] == 2'b11) begin
                    e_instr = {hw_at(exp_pc + 32'd2), h};
                    e_c     = 1'b0;
                end else begin
                    e_instr = {16'h0000, h};
                    e_c     = 1'b1;
                end
                checks++;
                if (pc_o !== exp_pc || instr_o !== e_instr || compressed_o !== e_c) begin
                    errors++;
                    $display("FAIL stream: got pc=%h instr=%h c=%b, expected pc=%h instr=%h c=%b",
                             pc_o, instr_o, compressed_o, exp_pc, e_instr, e_c);
                end
                exp_pc = exp_pc + (e_c ? 32'd2 : 32'd4);
                n_acc++;
            end
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst          = 1'b1;
        redirect_i   = 1'b0;
        icache_stall = 1'b0;
        ready_i      = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        exp_pc = RESET_PC;
        @(negedge clk);
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 20 && valid_o !== 1'b1; i++) step();
        checks++;
        if (valid_o !== 1'b1) begin
            errors++;
            $display("FAIL %s: valid_o=%b after 20 cycles, expected 1", name, valid_o);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
        rst = 1'b1; ready_i = 1'b1; icache_stall = 1'b0;
        redirect_i = 1'b0; redirect_pc_i = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (valid_o !== 1'b0 || instr_o !== 32'h0 || pc_o !== 32'h0 || compressed_o !== 1'b0 ||
            icache_ren !== 1'b0 || icache_addr !== RESET_PC[31:2]) begin
            errors++;
            $display("FAIL reset_state: valid=%b instr=%h pc=%h c=%b ren=%b addr=%h, expected all 0",
                     valid_o, instr_o, pc_o, compressed_o, icache_ren, icache_addr);
        end
        rst    = 1'b0;
        exp_pc = RESET_PC;
        #1;
        checks++;
        if (icache_ren !== 1'b1 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL first_request: ren=%b valid=%b, expected ren=1 valid=0", icache_ren, valid_o);
        end
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h0 || instr_o !== 32'h13 || compressed_o !== 1'b0) begin
            errors++;
            $display("FAIL first_output: valid=%b pc=%h instr=%h c=%b, expected 1 0 00000013 0",
                     valid_o, pc_o, instr_o, compressed_o);
        end
        for (int k = 1; k <= 2; k++) begin
            step();
            checks++;
            if (valid_o !== 1'b1 || pc_o !== 32'(4 * k) || instr_o !== 32'h13) begin
                errors++;
                $display("FAIL seq_pc: valid=%b pc=%h instr=%h, expected pc=%h instr=00000013",
                         valid_o, pc_o, instr_o, 32'(4 * k));
            end
        end
    endtask

    task automatic test_rvc_pair();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
        mem[0] = 32'h0001_0001;
        apply_reset();
        checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h0 || instr_o !== 32'h1 || compressed_o !== 1'b1 ||
            icache_addr !== 30'h1 || icache_ren !== 1'b0) begin
            errors++;
            $display("FAIL rvc_first: valid=%b pc=%h instr=%h c=%b addr=%h ren=%b, expected 1 0 1 1 1 0",
                     valid_o, pc_o, instr_o, compressed_o, icache_addr, icache_ren);
        end
        step();
        checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h2 || instr_o !== 32'h1 || compressed_o !== 1'b1 ||
            icache_addr !== 30'h1) begin
            errors++;
            $display("FAIL rvc_second: valid=%b pc=%h instr=%h c=%b addr=%h, expected 1 2 1 1 1",
                     valid_o, pc_o, instr_o, compressed_o, icache_addr);
        end
        repeat (3) step();
    endtask

    task automatic test_straddle();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
        mem[0] = 32'h0013_0001;
        mem[1] = 32'h1234_0000;
        apply_reset();
        checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h0 || instr_o !== 32'h1 || compressed_o !== 1'b1) begin
            errors++;
            $display("FAIL straddle_0: pc=%h instr=%h c=%b, expected 0 1 1", pc_o, instr_o, compressed_o);
        end
        step();
        checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h2 || instr_o !== 32'h13 || compressed_o !== 1'b0) begin
            errors++;
            $display("FAIL straddle_2: pc=%h instr=%h c=%b, expected 2 13 0", pc_o, instr_o, compressed_o);
        end
        step();
        checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h6 || instr_o !== 32'h1234 || compressed_o !== 1'b1) begin
            errors++;
            $display("FAIL straddle_6: pc=%h instr=%h c=%b, expected 6 1234 1", pc_o, instr_o, compressed_o);
        end
        repeat (2) step();
    endtask

    task automatic test_redirect();
        mem[8'h41] = 32'h4321_abcd;
        mem[8'h42] = 32'h0013_0001;
        mem[8'h43] = 32'h0001_0017;
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0106;
        step();
        redirect_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || icache_addr !== 30'h41) begin
            errors++;
            $display("FAIL redirect_addr: valid=%b addr=%h, expected 0 41", valid_o, icache_addr);
        end
        step();
        checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h106 || instr_o !== 32'h4321 || compressed_o !== 1'b1) begin
            errors++;
            $display("FAIL redirect_first: valid=%b pc=%h instr=%h c=%b, expected 1 106 4321 1",
                     valid_o, pc_o, instr_o, compressed_o);
        end
        // Upper-half target holding a 32-bit low half costs one empty cycle.
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_010a;
        step();
        redirect_i = 1'b0;
        step();
        checks++;
        if (valid_o !== 1'b0 || icache_addr !== 30'h43) begin
            errors++;
            $display("FAIL skip_buffer: valid=%b addr=%h, expected 0 43", valid_o, icache_addr);
        end
        step();
        checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h10a || instr_o !== 32'h0017_0013 || compressed_o !== 1'b0) begin
            errors++;
            $display("FAIL skip_join: valid=%b pc=%h instr=%h c=%b, expected 1 10a 00170013 0",
                     valid_o, pc_o, instr_o, compressed_o);
        end
        repeat (3) step();
    endtask

    task automatic test_drain();
        logic [29:0] old_addr;
        old_addr     = icache_addr;
        icache_stall = 1'b1;
        redirect_i   = 1'b1; redirect_pc_i = 32'h0000_0200;
        step();
        redirect_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (icache_addr !== old_addr || valid_o !== 1'b0 || icache_ren !== 1'b1) begin
                errors++;
                $display("FAIL drain_hold: addr=%h valid=%b ren=%b, expected addr=%h valid=0 ren=1",
                         icache_addr, valid_o, icache_ren, old_addr);
            end
            if (k < 3) step();
        end
        icache_stall = 1'b0;
        step();
        checks++;
        if (icache_addr !== 30'h80 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL drain_exit: addr=%h valid=%b, expected 80 0", icache_addr, valid_o);
        end
        step();
        checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h200 || instr_o !== 32'h13) begin
            errors++;
            $display("FAIL drain_first: valid=%b pc=%h instr=%h, expected 1 200 13", valid_o, pc_o, instr_o);
        end
    endtask

    task automatic test_hold();
        logic [31:0] h_instr, h_pc;
        logic        h_c;
        logic [29:0] h_addr;
        wait_valid("hold_valid");
        ready_i = 1'b0;
        h_instr = instr_o; h_pc = pc_o; h_c = compressed_o; h_addr = icache_addr;
        repeat (4) begin
            step();
            checks++;
            if (valid_o !== 1'b1 || instr_o !== h_instr || pc_o !== h_pc || compressed_o !== h_c ||
                icache_ren !== 1'b0 || icache_addr !== h_addr) begin
                errors++;
                $display("FAIL hold_stable: valid=%b pc=%h instr=%h ren=%b addr=%h, expected 1 %h %h 0 %h",
                         valid_o, pc_o, instr_o, icache_ren, icache_addr, h_pc, h_instr, h_addr);
            end
        end
        ready_i = 1'b1;
        step();
        checks++;
        if (valid_o !== 1'b1 || pc_o !== h_pc + 32'd4) begin
            errors++;
            $display("FAIL hold_resume: valid=%b pc=%h, expected 1 %h", valid_o, pc_o, h_pc + 32'd4);
        end
        ready_i = 1'b0;
        step();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (valid_o !== 1'b0 || instr_o !== 32'h0 || pc_o !== 32'h0 || compressed_o !== 1'b0 ||
            icache_ren !== 1'b0) begin
            errors++;
            $display("FAIL hold_async_reset: valid=%b instr=%h pc=%h c=%b ren=%b, expected all 0",
                     valid_o, instr_o, pc_o, compressed_o, icache_ren);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int start;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        apply_reset();
        start = n_acc;
        for (int c = 0; c < 3000; c++) begin
            icache_stall  = ($urandom % 4) == 0;
            ready_i       = ($urandom % 4) != 0;
            redirect_i    = ($urandom % 40) == 0;
            redirect_pc_i = $urandom_range(0, 32'h3c0);
            step();
        end
        redirect_i = 1'b0; icache_stall = 1'b0; ready_i = 1'b1;
        checks++;
        if (n_acc - start < 300) begin
            errors++;
            $display("FAIL random_progress: %0d instructions accepted, expected at least 300", n_acc - start);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rvc_pair();
        test_straddle();
        test_redirect();
        test_drain();
        test_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_aligner.md
Name: fetch_aligner

Overview:
- Instruction-fetch front end between the I-cache and the pipeline IF/ID register.
- Fetches 32-bit words from the I-cache and realigns the halfword stream containing mixed 32-bit and 16-bit (RVC) instructions.
- Presents one instruction per valid/ready handshake with its PC and a compressed flag.
- Decompression is done downstream; this block only does length detection, alignment, buffering and redirect handling.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset; bit 0 must be 0.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- icache_ren  output  1  read request
- icache_addr  output  30  word address (byte address [31:2])
- icache_stall  input  1  1 = word at icache_addr not yet available
- icache_rdata  input  32  fetched word, cache byte order (byte-swapped before use)
- redirect_i  input  1  branch/jump taken; load new fetch PC
- redirect_pc_i  input  32  target byte address; bit 0 ignored
- valid_o  output  1  instr_o/pc_o/compressed_o valid
- ready_i  input  1  downstream accepts (pipeline drives ~stall)
- instr_o  output  32  instruction; RVC is zero-extended to {16'h0, hw}
- pc_o  output  32  byte address of instr_o
- compressed_o  output  1  1 = 16-bit instruction

Behaviour:
- **Reset (async, rst=1):**
  - fetch_addr = RESET_PC[31:2]; skip_low = RESET_PC[1].
  - hbuf_v = 0; state = RUN.
  - valid_o = 0, instr_o = 0, pc_o = 0, compressed_o = 0.
  - icache_ren = 0 while rst is high.
  - Reset mid-miss drops everything. The cache must tolerate its address changing.
- **Byte order:** w = {rdata[7:0], rdata[15:8], rdata[23:16], rdata[31:24]}.
  - Low halfword w[15:0] is at 4k; high halfword w[31:16] is at 4k+2.
- **Length rule:** a halfword h starts a 32-bit instruction iff h[1:0] == 2'b11; otherwise it is RVC.
- **Internal state:**
  - hbuf[15:0], hbuf_v, hbuf_pc: leftover upper halfword.
  - skip_low: first word after a redirect to a PC with bit 1 set.
  - pend_pc: held redirect target.
- **Output slot:** a register. It loads when (!valid_o || ready_i). It holds stable while valid_o && !ready_i.
- **Word consumed:** only when the slot can load and icache_stall = 0. Consuming a word increments fetch_addr by 1 (30-bit wrap).
- **Load cases**, evaluated in priority order:
  - A. hbuf_v and hbuf is RVC: emit hbuf at hbuf_pc, compressed; clear hbuf_v; no cache word used; icache_ren = 0.
  - B. hbuf_v and hbuf is 32-bit low half: needs word; emit {w[15:0], hbuf} at hbuf_pc; hbuf = w[31:16]; hbuf_pc = 4*fetch_addr+2; hbuf_v = 1; consume.
  - C. skip_low: if w[31:16] is RVC, emit it at 4*fetch_addr+2. Otherwise buffer it (hbuf_v = 1) and leave the slot empty. Consume; clear skip_low.
  - D. otherwise, if w[1:0] == 11: emit w at 4*fetch_addr; consume.
  - E. otherwise: emit w[15:0] compressed; hbuf = w[31:16] at +2; hbuf_v = 1; consume.
- **icache_ren:** 1 in state RUN when the slot can load and case A does not apply; also 1 in DRAIN.
- **Redirect with icache_stall = 0, state RUN:**
  - Next edge: valid_o = 0, hbuf_v = 0, fetch_addr = redirect_pc_i[31:2], skip_low = redirect_pc_i[1].
  - The current word is discarded.
  - Redirect overrides a pending handshake (ready_i is ignored that cycle).
- **Redirect with icache_stall = 1:**
  - state -> DRAIN; pend_pc = redirect_pc_i; valid_o = 0, hbuf_v = 0.
  - icache_addr stays on the old address.
- **DRAIN:**
  - Remains while icache_stall = 1.
  - On the first icache_stall = 0 cycle, the returned word is discarded; fetch_addr = pend_pc[31:2], skip_low = pend_pc[1], state -> RUN.
  - A new redirect in DRAIN overwrites pend_pc.
- **Latency:** redirect at cycle t, hit at t+1 → icache_addr = target at t+1, valid_o = 1 at t+2.
- **Steady state:** hits sustain one instruction per cycle, except the extra cycle when case C buffers a 32-bit low half.

Decomposition:
- Package fetch_pkg holds:
  - localparam ST_RUN = 1'b0, ST_DRAIN = 1'b1.
  - localparam OPC_LEN32 = 2'b11.
  - A function is_rvc(h) returning (h[1:0] != OPC_LEN32).
- No sub-module. The byte swap and the case mux stay inline.
- Decompressor rvc_expand is a separate downstream block.

Test Plan:
1. Reset, RESET_PC = 0; cache hits every word with swapped w = 32'h0000_0013 → after rst falls, valid_o first at cycle 2; pc_o = 0, 4, 8 on consecutive cycles; instr_o = 32'h0000_0013; compressed_o = 0.
2. w = 32'h0001_0001 at addr 0 → two outputs: pc_o = 0 then 2, instr_o = 32'h0000_0001, compressed_o = 1; icache_addr advances 0 → 1 only once; icache_ren = 0 during the second output.
3. Straddle: word0 w = 32'h0013_0001, word1 w = 32'h1234_0000 → pc 0 RVC 32'h0000_0001, then pc 2 32-bit instr 32'h0000_0013, then pc 6 with hbuf = 16'h1234 handled per the length rule.
4. redirect_pc_i = 32'h0000_0106, stall = 0 → next cycle icache_addr = 30'h41; low half ignored; first valid pc_o = 32'h106, no stale output.
5. Redirect to 32'h200 while icache_stall = 1 for 3 more cycles → icache_addr holds the old value; the word returned at stall drop is discarded; then icache_addr = 30'h80; no valid_o with an old PC.
6. ready_i = 0 for 4 cycles with valid_o = 1 → instr_o/pc_o/compressed_o stable, icache_ren = 0, fetch_addr constant; ready_i = 1 resumes with no lost or duplicated instruction. Repeat with rst asserted mid-hold → all outputs 0 immediately (async).
